// File: rtl/commit_map_table.sv
// Committed architectural-to-physical register map: returns superseded tags to the free list on
// commit and streams the whole map on rewind. Define COMMIT_MAP_ZERO_REG_EN to hard-wire arch reg 0.
module commit_map_table #(
    parameter int  ARCH_REGS = 32,
    parameter int  TAG_W     = 6,
    localparam int IDX_W     = $clog2(ARCH_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             commitValid,
    output logic             commitReady,
    input  logic             commitHasDest,
    input  logic [IDX_W-1:0] commitArch,
    input  logic [TAG_W-1:0] commitPhys,
    output logic             put,
    output logic             enablePut,
    output logic [TAG_W-1:0] writePut,
    input  logic             rewind,
    output logic             dumpValid,
    output logic [IDX_W-1:0] dumpArch,
    output logic [TAG_W-1:0] dumpPhys,
    output logic             dumpBusy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARCH_REGS - 1);

    typedef enum logic {
        IDLE,
        DUMP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W-1:0] dump_sel;
    logic [TAG_W-1:0] map [ARCH_REGS];

    logic             accept;
    logic             zero_dest;
    logic             write_map;
    logic             free_valid;
    logic [TAG_W-1:0] free_tag;

    // A commit to the hard-wired zero register frees its own tag instead of the mapped one.
`ifdef COMMIT_MAP_ZERO_REG_EN
    assign zero_dest = (commitArch == '0);
`else
    assign zero_dest = 1'b0;
`endif

    assign commitReady = en && (state == IDLE) && !rewind;
    assign accept      = commitValid && commitReady;
    assign free_valid  = accept && commitHasDest;
    assign write_map   = free_valid && !zero_dest;
    // Reading the live array lets a same-register commit on the next cycle see this cycle's write.
    assign free_tag    = zero_dest ? commitPhys : map[commitArch];

    // NOTE: every register below uses non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // NOTE: defaults first in every combinational block, otherwise unassigned paths infer latches.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        if (en) begin
            unique case (state)
                IDLE: begin
                    if (rewind) begin
                        state_next = DUMP;
                        idx_next   = '0;
                    end
                end
                DUMP: begin
                    if (rewind) begin
                        idx_next = '0;
                    end else if (idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        dumpValid = 1'b0;
        dumpBusy  = 1'b0;
        dump_sel  = '0;
        if (state == DUMP) begin
            dumpValid = en;
            dumpBusy  = 1'b1;
            dump_sel  = idx;
        end
    end

    assign dumpArch = dump_sel;
    assign dumpPhys = map[dump_sel];

    // NOTE: the map resets to identity, so it is a flop array and cannot map onto a reset-less RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map[i] <= TAG_W'(i);
            end
        end else if (write_map) begin
            map[commitArch] <= commitPhys;
        end
    end

    // The put pulse is not gated by en beyond accept: a frozen cycle must still clear it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            put       <= 1'b0;
            enablePut <= 1'b0;
            writePut  <= '0;
        end else begin
            put       <= accept;
            enablePut <= free_valid;
            writePut  <= free_valid ? free_tag : '0;
        end
    end

endmodule

// File: doc/commit_map_table.md
# commit_map_table

Retirement-side companion to the rename free list. Holds the committed architectural-to-physical register map (32 arch regs, 6-bit physical tags). On each committed instruction it records the new mapping and returns the superseded physical tag to the free list through its put/enablePut/writePut port. On a rewind it streams the full committed map, one entry per cycle, so the speculative rename map can be rebuilt.

## Interface
- ARCH_REGS, 32: number of architectural registers; index width is 5.
- TAG_W, 6: physical tag width; must match the free list.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; asserting it (0) clears state immediately.
- en  in  1  global enable; 0 freezes all state.
- commitValid  in  1  a committing instruction is presented.
- commitReady  out  1  commit accepted at this edge if commitValid is also high.
- commitHasDest  in  1  instruction really writes a destination register.
- commitArch  in  5  architectural destination index.
- commitPhys  in  TAG_W  physical tag allocated to it at rename.
- put  out  1  registered; to free list `put`, one pulse per accepted commit.
- enablePut  out  1  registered; to free list `enablePut`.
- writePut  out  TAG_W  registered; freed physical tag.
- rewind  in  1  start or restart a map dump.
- dumpValid  out  1  dumpArch/dumpPhys carry a valid map entry this cycle.
- dumpArch  out  5  index of dumped entry.
- dumpPhys  out  TAG_W  committed tag of that entry.
- dumpBusy  out  1  high while in DUMP.

## Operation
- Reset state: map[i] = i for i in 0..31 (matches free list initially holding 32..63); state IDLE; dump index 0; put = 0, enablePut = 0, writePut = 0, dumpValid = 0, dumpBusy = 0, dumpArch = 0.
- States: IDLE, DUMP.
- commitReady = en & (state == IDLE) & ~rewind.
- Accepted commit (commitValid & commitReady at edge):
  - if commitHasDest: map[commitArch] <= commitPhys; next-cycle writePut = old map[commitArch], enablePut = 1.
  - if not: map unchanged; enablePut = 0, writePut = 0.
  - put = 1 in both cases (command pulse even with nothing to free).
- No accepted commit at an edge with en = 1: put, enablePut, writePut all 0 next cycle.
- Map read is combinational on the current array contents, so back-to-back commits to the same arch reg free the correct tag with no stall: commit r5->40 then r5->41 frees 5, then 40.
- IDLE -> DUMP when rewind & en at an edge; the dump index is set to 0.
- In DUMP: dumpValid = en, dumpArch = index, dumpPhys = map[index]; the index increments on each edge with en. After index 31 is emitted the state returns to IDLE and the index goes to 0.
- rewind & en during DUMP restarts the dump at index 0 (state stays DUMP).
- In IDLE: dumpValid = 0, dumpArch = 0, dumpPhys = map[0].
- Commits are refused throughout DUMP and on the rewind cycle itself. A put already registered before rewind still appears in the following cycle.
- en = 0: map, state and index hold; put, enablePut and writePut are driven 0 next cycle; dumpValid = 0.

## Timing
- Commit-to-put latency: 1 cycle (accept at edge N; put visible in cycle N..N+1).
- Throughput: 1 commit per cycle in IDLE.
- Dump: rewind at edge N; entry k valid in cycle N+k (k = 0..31); dumpBusy falls after edge N+32; commitReady rises in the cycle after edge N+32, or later if rewind is still held.
- Reset asserted mid-dump or mid-commit: immediate return to reset state; any pending put is lost.

## Configuration
- COMMIT_MAP_ZERO_REG_EN defined: arch reg 0 is hard-wired.
  - A commit with hasDest to arch 0 leaves map[0] = 0.
  - It frees commitPhys itself (writePut = commitPhys, enablePut = 1).
  - The dump still reports entry 0 as tag 0.
- Undefined: arch 0 is an ordinary register.

## Test plan
- Reset then one commit (hasDest=1, arch 3, phys 33) -> next cycle put=1, enablePut=1, writePut=3; then rewind -> entry 3 dumps as 33.
- Commit with hasDest=0 (arch 7, phys 50) -> put=1, enablePut=0, writePut=0; map[7] stays 7.
- Back-to-back commits r5->40, r5->41 -> writePut 5 then 40 on consecutive cycles; dump shows map[5]=41.
- Rewind -> dumpValid for 32 cycles, entries 0..31 in order; commitReady=0 throughout. Rewind again at dump index 10 -> dump restarts at 0. Reset at index 20 -> dumpBusy=0 and map identity immediately.
- en=0 for 3 cycles mid-dump at index 4 -> index holds, dumpValid=0; resumes at 4.
- With COMMIT_MAP_ZERO_REG_EN, commit arch 0 phys 45 -> writePut=45, enablePut=1, map[0]=0. Without the macro -> writePut=0, map[0]=45.
